// File: rtl/seg_reader.sv
// seg_reader: recovers hex nibbles from strobed active-low 7-segment patterns and packs DIGITS of them into a word
//   clk, rst      : clock, synchronous active-high reset
//   seg_in[0:6]   : segment pattern, index 0 = a .. 6 = g, active-low
//   seg_stb       : digit-present strobe, only looked at while idle
//   value         : last completed word, first received digit in the top nibble
//   done          : one-cycle pulse marking a completed word
//   err           : some digit of the completed word was not a hex pattern
//   busy          : mid-digit or holding a partial word
module seg_reader #(
  parameter int DIGITS = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:6]        seg_in,
  input  logic              seg_stb,
  output logic [4*DIGITS-1:0] value,
  output logic              done,
  output logic              err,
  output logic              busy
);
  localparam int W = 4 * DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int DW = $clog2(DIGITS + 1);
  typedef enum logic [1:0] {IDLE, CHECK, STORE, DONE_ST} state_t;
  state_t state, state_n;
  logic [0:6] p;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic [W-1:0] acc;
  logic err_acc, inv, same, stable, last;
  logic [3:0] nib;
  always_comb begin
    inv = 1'b0;
    nib = 4'h0;
    case (p)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001101: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      default:    inv = 1'b1;
    endcase
  end
  always_comb begin
    same = seg_in == p;
    stable = same && (cnt + CW'(1)) == CW'(STABLE_CYCLES);
    last = dcnt == DW'(DIGITS - 1);
    state_n = state == IDLE  ? (seg_stb ? CHECK : IDLE) :
              state == CHECK ? (stable ? STORE : CHECK) :
              state == STORE ? (last ? DONE_ST : IDLE) : IDLE;
    done = state == DONE_ST;
    busy = state != IDLE || dcnt != '0;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      cnt <= '0;
      dcnt <= '0;
      acc <= '0;
      err_acc <= 1'b0;
      value <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (seg_stb) begin
          p <= seg_in;
          cnt <= CW'(1);
        end
        CHECK: begin
          // any change restarts the stability window on the new pattern
          p <= seg_in;
          cnt <= same ? cnt + CW'(1) : CW'(1);
        end
        STORE: begin
          acc <= W'({acc, nib});
          err_acc <= err_acc | inv;
          dcnt <= dcnt + DW'(1);
        end
        DONE_ST: begin
          value <= acc;
          err <= err_acc;
          acc <= '0;
          dcnt <= '0;
          err_acc <= 1'b0;
        end
      endcase
    end
  end
endmodule
